// File: rtl/uart_pkg.sv
// Shared UART definitions: character width and the transmit sequencer state encoding.
package uart_pkg;

  localparam int UART_CHAR_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE    = 2'd0,
    TXF_STROBE  = 2'd1,
    TXF_WAIT_HI = 2'd2,
    TXF_WAIT_LO = 2'd3
  } txf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with explicit occupancy count and synchronous flush.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Full is judged on the registered count, so a push while full is refused even alongside a pop.
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Character queue between the debug print engine and uarttx, drained one frame at a time
// through the txen/busy handshake with a bounded wait for busy to acknowledge each strobe.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 3,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [UART_CHAR_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  input  logic                   uartbusy,
  output logic [UART_CHAR_W-1:0] charout,
  output logic                   uarttxen,
  output logic                   idle
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  txf_state_e             state;
  txf_state_e             state_next;
  logic [TW-1:0]          timer;
  logic [TW-1:0]          timer_next;
  logic                   pop;
  logic [UART_CHAR_W-1:0] pop_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_CHAR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A flush in the same cycle as a would-be pop wins: the queue is cleared and nothing is sent.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    case (state)
      TXF_IDLE: begin
        if (!empty && !uartbusy && !flush) begin
          pop        = 1'b1;
          state_next = TXF_STROBE;
        end
      end
      TXF_STROBE: begin
        state_next = TXF_WAIT_HI;
        timer_next = '0;
      end
      TXF_WAIT_HI: begin
        if (uartbusy) begin
          state_next = TXF_WAIT_LO;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = TXF_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      TXF_WAIT_LO: begin
        if (!uartbusy) begin
          state_next = TXF_IDLE;
        end
      end
      default: begin
        state_next = TXF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TXF_IDLE;
      timer    <= '0;
      uarttxen <= 1'b0;
      charout  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      uarttxen <= (state_next == TXF_STROBE);
      if (pop) begin
        charout <= pop_data;
      end
      if (flush) begin
        overflow <= 1'b0;
      end else if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign idle = empty && (state == TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, corner-case sequences and randomized traffic
// compared every cycle against a queue-based model of the queue and the send handshake.
module tb_uart_tx_fifo;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uartbusy = 1'b0;
  logic       full, empty, overflow, uarttxen, idle;
  logic [4:0] count;
  logic [7:0] charout;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .uartbusy(uartbusy), .charout(charout), .uarttxen(uarttxen), .idle(idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a byte queue plus the phase of the frame currently being sent.
  typedef enum int {SND_READY, SND_KICK, SND_ACK, SND_DRAIN} snd_t;
  logic [7:0] mq[$];
  bit         m_ovf   = 0;
  logic [7:0] m_char  = 8'h00;
  bit         m_txen  = 0;
  snd_t       m_snd   = SND_READY;
  int         m_quiet = 0;

  task automatic model_step(input bit r, input bit f, input bit w, input logic [7:0] d, input bit b);
    bit was_full;
    bit take;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_char = 8'h00; m_snd = SND_READY; m_quiet = 0; m_txen = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      take = (m_snd == SND_READY) && (mq.size() != 0) && !b && !f;
      case (m_snd)
        SND_READY: if (take) m_snd = SND_KICK;
        SND_KICK:  begin m_snd = SND_ACK; m_quiet = 0; end
        SND_ACK: begin
          if (b) m_snd = SND_DRAIN;
          else begin
            m_quiet++;
            if (m_quiet == BUSY_TIMEOUT) m_snd = SND_READY;
          end
        end
        default: if (!b) m_snd = SND_READY;
      endcase
      if (f) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        if (take) m_char = mq.pop_front();
        if (w) begin
          if (!was_full) mq.push_back(d);
          else m_ovf = 1;
        end
      end
      m_txen = (m_snd == SND_KICK);
    end
  endtask

  // uarttx stand-in: 0 tied low, 1 responds to strobes, 2 held high, 3 driven from busy_force.
  int utx_mode = 0;
  bit utx_rand = 0;
  int utx_delay = 0, utx_len = 10;
  int rise_in = -1, hold = 0, hold_len = 0;
  bit busy_force = 0;

  task automatic gen_busy();
    if (m_txen && utx_mode == 1) begin
      rise_in  = (utx_rand ? int'($urandom_range(4, 0)) : utx_delay) + 1;
      hold_len = utx_rand ? int'($urandom_range(12, 1)) : utx_len;
    end else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin hold = hold_len; rise_in = -1; end
    end
    case (utx_mode)
      0: uartbusy = 1'b0;
      2: uartbusy = 1'b1;
      3: uartbusy = busy_force;
      default: begin
        uartbusy = (hold > 0);
        if (hold > 0) hold--;
      end
    endcase
  endtask

  logic [7:0] dut_tx[$];
  int         tx_cyc[$];

  task automatic apply(input bit r, input bit f, input bit w, input logic [7:0] d);
    rst = r; flush = f; wr_en = w; wr_data = d;
    gen_busy();
    @(posedge clk);
    model_step(r, f, w, d, uartbusy);
    #1;
    cyc++;
    if (uarttxen === 1'b1) begin
      dut_tx.push_back(charout);
      tx_cyc.push_back(cyc);
    end
  endtask

  task automatic check_model();
    check("count", int'(count), mq.size());
    check("empty", int'(empty), int'(mq.size() == 0));
    check("full", int'(full), int'(mq.size() == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
    check("uarttxen", int'(uarttxen), int'(m_txen));
    check("charout", int'(charout), int'(m_char));
    check("idle", int'(idle), int'(mq.size() == 0 && m_snd == SND_READY));
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 8'h00);
    apply(0, 0, 0, 8'h00);
    dut_tx.delete();
    tx_cyc.delete();
  endtask

  typedef struct {
    bit r; bit f; bit w; logic [7:0] d; bit b;
    int cnt; bit emp; bit ful; bit ovf; bit txen; logic [7:0] ch; bit idl;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ok;
    int bad;
    int pops;
    bit done;
    logic [7:0] nv;
    logic [7:0] exp_q[$];

    //           r f w d      b  cnt emp ful ovf txen ch    idl
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 1};
    tbl[1]  = '{0, 0, 1, 8'h41, 0, 1, 0, 0, 0, 0, 8'h00, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h41, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h41, 0};
    tbl[4]  = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h41, 0};
    tbl[5]  = '{0, 0, 1, 8'h42, 1, 1, 0, 0, 0, 0, 8'h41, 0};
    tbl[6]  = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h41, 0};
    tbl[7]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h42, 0};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h42, 0};
    tbl[9]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h42, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h42, 0};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h42, 1};
    tbl[12] = '{0, 0, 1, 8'h43, 0, 1, 0, 0, 0, 0, 8'h42, 0};
    tbl[13] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h43, 0};
    tbl[14] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 1};

    // Reset held two cycles, then 50 quiet cycles.
    utx_mode = 0;
    apply(1, 0, 0, 8'h00);
    apply(1, 0, 0, 8'h00);
    check_model();
    dut_tx.delete();
    for (int i = 0; i < 50; i++) begin
      apply(0, 0, 0, 8'h00);
      check_model();
    end
    check("idle_no_txen", dut_tx.size(), 0);

    // Directed vectors: single char, busy handshake, timeout, reset mid-frame.
    utx_mode = 3;
    for (int i = 0; i < 15; i++) begin
      busy_force = tbl[i].b;
      apply(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].d);
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      check($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].emp));
      check($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].ful));
      check($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].ovf));
      check($sformatf("tbl%0d_uarttxen", i), int'(uarttxen), int'(tbl[i].txen));
      check($sformatf("tbl%0d_charout", i), int'(charout), int'(tbl[i].ch));
      check($sformatf("tbl%0d_idle", i), int'(idle), int'(tbl[i].idl));
    end

    // Burst 30..3F while busy is high, then drain in order.
    do_reset();
    utx_mode = 2;
    for (int i = 0; i < 16; i++) begin
      apply(0, 0, 1, 8'h30 + 8'(i));
      check_model();
    end
    check("burst_full", int'(full), 1);
    check("burst_count", int'(count), 16);
    utx_mode = 1; utx_rand = 0; utx_delay = 0; utx_len = 10;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      apply(0, 0, 0, 8'h00);
      check_model();
      done = (mq.size() == 0) && (m_snd == SND_READY);
    end
    check("burst_drained", int'(done), 1);
    check("burst_tx_n", dut_tx.size(), 16);
    n_ok = 0;
    for (int i = 0; i < dut_tx.size() && i < 16; i++)
      if (dut_tx[i] == 8'h30 + 8'(i)) n_ok++;
    check("burst_order", n_ok, 16);
    check("burst_empty", int'(empty), 1);

    // Overflow while full, then flush during an in-flight frame.
    do_reset();
    utx_mode = 2;
    for (int i = 0; i < 16; i++) begin
      apply(0, 0, 1, 8'hA0 + 8'(i));
      check_model();
    end
    apply(0, 0, 1, 8'hEE);
    check_model();
    check("ovf_count", int'(count), 16);
    check("ovf_flag", int'(overflow), 1);
    utx_mode = 1; utx_rand = 0; utx_delay = 0; utx_len = 8;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 8'h00);
      check_model();
    end
    apply(0, 1, 0, 8'h00);
    check_model();
    check("flush_count", int'(count), 0);
    check("flush_ovf", int'(overflow), 0);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      apply(0, 0, 0, 8'h00);
      check_model();
      done = (m_snd == SND_READY);
    end
    check("flush_frame_done", int'(idle), 1);
    check("flush_tx_n", dut_tx.size(), 1);
    check("flush_tx0", int'(dut_tx.size() > 0 ? dut_tx[0] : 8'h00), 8'hA0);

    // Busy never rises: each strobe times out and the next byte follows.
    do_reset();
    utx_mode = 0;
    apply(0, 0, 1, 8'h55);
    check_model();
    apply(0, 0, 1, 8'h56);
    check_model();
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 8'h00);
      check_model();
    end
    check("tmo_tx_n", dut_tx.size(), 2);
    check("tmo_tx0", int'(dut_tx.size() > 0 ? dut_tx[0] : 8'h00), 8'h55);
    check("tmo_tx1", int'(dut_tx.size() > 1 ? dut_tx[1] : 8'h00), 8'h56);
    check("tmo_gap", (tx_cyc.size() > 1) ? tx_cyc[1] - tx_cyc[0] : 0, 2 + BUSY_TIMEOUT);

    // Occupancy held at 3 by pushing on every pop cycle; pointers wrap.
    do_reset();
    utx_mode = 3; busy_force = 1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
      check_model();
    end
    nv = 8'h83; pops = 0; bad = 0;
    for (int i = 0; i < 2000 && pops < 40; i++) begin
      busy_force = ($urandom_range(1, 0) == 1);
      if (m_snd == SND_READY && mq.size() != 0 && !busy_force) begin
        apply(0, 0, 1, nv);
        exp_q.push_back(nv);
        nv++;
        pops++;
      end else begin
        apply(0, 0, 0, 8'h00);
      end
      check_model();
      if (count != 5'd3) bad++;
    end
    check("wrap_pops", pops, 40);
    check("wrap_count_const", bad, 0);
    check("wrap_tx_n", dut_tx.size(), 40);
    n_ok = 0;
    for (int i = 0; i < dut_tx.size() && i < 40; i++)
      if (dut_tx[i] == exp_q[i]) n_ok++;
    check("wrap_order", n_ok, 40);

    // Randomized traffic, flushes, resets and uarttx behaviours.
    do_reset();
    utx_mode = 1; utx_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0)
        utx_mode = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 0 : 2) : 1;
      apply($urandom_range(999, 0) < 3, $urandom_range(99, 0) == 0,
            $urandom_range(99, 0) < 45, 8'($urandom_range(255, 0)));
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
